// File: rtl/layer_address_sequencer_if.sv
// Bundles the layer configuration, control and memory-address signals of the
// layer address sequencer. The master drives configuration and control; the
// slave (the sequencer) drives the address and strobe outputs.
interface layer_address_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
);
  // Control and configuration (master -> sequencer)
  logic              start;
  logic              stall;
  logic [CNT_W-1:0]  n_in;
  logic [CNT_W-1:0]  n_out;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] in_base;
  logic [ADDR_W-1:0] out_base;

  // Addresses and strobes (sequencer -> master)
  logic [ADDR_W-1:0] weight_read_addr;
  logic [ADDR_W-1:0] neuro_read_addr;
  logic [ADDR_W-1:0] neuro_write_addr;
  logic              mac_valid;
  logic              acc_clear;
  logic              bias_sel;
  logic              write_en;
  logic              busy;
  logic              finished;

  modport master (
    output start, stall, n_in, n_out, w_base, in_base, out_base,
    input  weight_read_addr, neuro_read_addr, neuro_write_addr,
    input  mac_valid, acc_clear, bias_sel, write_en, busy, finished
  );

  modport slave (
    input  start, stall, n_in, n_out, w_base, in_base, out_base,
    output weight_read_addr, neuro_read_addr, neuro_write_addr,
    output mac_valid, acc_clear, bias_sel, write_en, busy, finished
  );
endinterface

// File: rtl/layer_address_sequencer.sv
// Walks one neural-network layer: for each output neuron, issues n_in MAC
// cycles (plus an optional bias cycle) and then one write-back cycle.
// Latency: first MAC one cycle after start; every output is a register.
// Stall sampled at a clock edge turns the following cycle into a bubble.
module layer_address_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 8,
  parameter int BIAS_EN = 1
) (
  input logic                    clk,
  input logic                    reset,
  layer_address_sequencer_if.slave bus
);

  // The state names the kind of the next operation to issue; the output
  // registers hold the operation issued at the last edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  i_q;
  logic [CNT_W-1:0]  j_q;
  logic [ADDR_W-1:0] w_ptr_q;

  // Configuration latched at start; later input changes are not observed.
  logic [CNT_W-1:0]  n_in_q;
  logic [CNT_W-1:0]  n_out_q;
  logic [ADDR_W-1:0] in_base_q;
  logic [ADDR_W-1:0] out_base_q;

  // Registered outputs
  logic [ADDR_W-1:0] weight_read_addr_q;
  logic [ADDR_W-1:0] neuro_read_addr_q;
  logic [ADDR_W-1:0] neuro_write_addr_q;
  logic              mac_valid_q;
  logic              acc_clear_q;
  logic              bias_sel_q;
  logic              write_en_q;
  logic              busy_q;
  logic              finished_q;

  // View of the operation to issue at this edge. A launching start supplies
  // the first MAC straight from the inputs so it appears one cycle later.
  state_t            cur_state;
  logic [CNT_W-1:0]  cur_i;
  logic [CNT_W-1:0]  cur_j;
  logic [ADDR_W-1:0] cur_w;
  logic [CNT_W-1:0]  cur_n_in;
  logic [CNT_W-1:0]  cur_n_out;
  logic [ADDR_W-1:0] cur_in_base;
  logic [ADDR_W-1:0] cur_out_base;
  logic              start_ok;
  logic              launch;
  logic              empty_layer;
  logic              hold;
  logic              is_bias;
  logic              last_mac;
  logic              last_out;

  // Select the pending operation and decode its end-of-loop conditions.
  always_comb begin
    // start is only honoured while the visible status is idle (busy low),
    // so a start during the finished pulse is ignored.
    start_ok    = (state_q == IDLE) && !busy_q && bus.start;
    launch      = start_ok && (bus.n_in != '0) && (bus.n_out != '0);
    empty_layer = start_ok && !launch;

    cur_state    = state_q;
    cur_i        = i_q;
    cur_j        = j_q;
    cur_w        = w_ptr_q;
    cur_n_in     = n_in_q;
    cur_n_out    = n_out_q;
    cur_in_base  = in_base_q;
    cur_out_base = out_base_q;

    if (launch) begin
      cur_state    = RUN;
      cur_i        = '0;
      cur_j        = '0;
      cur_w        = bus.w_base;
      cur_n_in     = bus.n_in;
      cur_n_out    = bus.n_out;
      cur_in_base  = bus.in_base;
      cur_out_base = bus.out_base;
    end else if (empty_layer) begin
      cur_state = DONE;
    end

    // Stall only freezes the MAC/write loop; launch, DONE and IDLE ignore it.
    hold = bus.stall && !launch && ((state_q == RUN) || (state_q == WRITE));

    // With a bias term the loop runs one extra step at i == n_in.
    is_bias  = (BIAS_EN != 0) && (cur_i == cur_n_in);
    last_mac = (BIAS_EN != 0) ? is_bias : (cur_i == cur_n_in - CNT_W'(1));
    last_out = (cur_j == cur_n_out - CNT_W'(1));
  end

  // Sequencer FSM: issue one operation per unstalled edge and advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      i_q                <= '0;
      j_q                <= '0;
      w_ptr_q            <= '0;
      n_in_q             <= '0;
      n_out_q            <= '0;
      in_base_q          <= '0;
      out_base_q         <= '0;
      weight_read_addr_q <= '0;
      neuro_read_addr_q  <= '0;
      neuro_write_addr_q <= '0;
      mac_valid_q        <= 1'b0;
      acc_clear_q        <= 1'b0;
      bias_sel_q         <= 1'b0;
      write_en_q         <= 1'b0;
      busy_q             <= 1'b0;
      finished_q         <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-issued below.
      mac_valid_q <= 1'b0;
      acc_clear_q <= 1'b0;
      bias_sel_q  <= 1'b0;
      write_en_q  <= 1'b0;
      finished_q  <= 1'b0;

      if (launch) begin
        n_in_q     <= bus.n_in;
        n_out_q    <= bus.n_out;
        in_base_q  <= bus.in_base;
        out_base_q <= bus.out_base;
      end

      if (hold) begin
        // Bubble: position and addresses frozen, layer still in progress.
        busy_q <= 1'b1;
      end else begin
        case (cur_state)
          RUN: begin
            mac_valid_q        <= 1'b1;
            acc_clear_q        <= (cur_i == '0);
            bias_sel_q         <= is_bias;
            weight_read_addr_q <= cur_w;
            neuro_read_addr_q  <= cur_in_base + ADDR_W'(cur_i);
            busy_q             <= 1'b1;
            // Weights are contiguous across neurons, so w_ptr never rewinds.
            w_ptr_q            <= cur_w + ADDR_W'(1);
            j_q                <= cur_j;
            if (last_mac) begin
              state_q <= WRITE;
              i_q     <= cur_i;
            end else begin
              state_q <= RUN;
              i_q     <= cur_i + CNT_W'(1);
            end
          end
          WRITE: begin
            write_en_q         <= 1'b1;
            neuro_write_addr_q <= cur_out_base + ADDR_W'(cur_j);
            busy_q             <= 1'b1;
            if (last_out) begin
              state_q <= DONE;
            end else begin
              state_q <= RUN;
              i_q     <= '0;
              j_q     <= cur_j + CNT_W'(1);
            end
          end
          DONE: begin
            finished_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.weight_read_addr = weight_read_addr_q;
  assign bus.neuro_read_addr  = neuro_read_addr_q;
  assign bus.neuro_write_addr = neuro_write_addr_q;
  assign bus.mac_valid        = mac_valid_q;
  assign bus.acc_clear        = acc_clear_q;
  assign bus.bias_sel         = bias_sel_q;
  assign bus.write_en         = write_en_q;
  assign bus.busy             = busy_q;
  assign bus.finished         = finished_q;

endmodule

// File: tb/tb_layer_address_sequencer.sv
// Bench for layer_address_sequencer: two instances (with and without bias
// term) driven identically; a queue-based layer model predicts every cycle.
module tb_layer_address_sequencer;
  localparam int AW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start, stall;
  logic [CW-1:0] n_in, n_out;
  logic [AW-1:0] w_base, in_base, out_base;

  layer_address_sequencer_if #(.ADDR_W(AW), .CNT_W(CW)) bus1 ();
  layer_address_sequencer_if #(.ADDR_W(AW), .CNT_W(CW)) bus0 ();

  assign bus1.start = start;    assign bus0.start = start;
  assign bus1.stall = stall;    assign bus0.stall = stall;
  assign bus1.n_in = n_in;      assign bus0.n_in = n_in;
  assign bus1.n_out = n_out;    assign bus0.n_out = n_out;
  assign bus1.w_base = w_base;  assign bus0.w_base = w_base;
  assign bus1.in_base = in_base;   assign bus0.in_base = in_base;
  assign bus1.out_base = out_base; assign bus0.out_base = out_base;

  layer_address_sequencer #(.ADDR_W(AW), .CNT_W(CW), .BIAS_EN(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  layer_address_sequencer #(.ADDR_W(AW), .CNT_W(CW), .BIAS_EN(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  // flags = {busy, finished, mac_valid, acc_clear, bias_sel, write_en}
  typedef struct {
    logic [5:0] flags;
    logic [7:0] wra;
    logic [7:0] nra;
    logic [7:0] nwa;
    bit         rd_chk;
    bit         wr_chk;
  } rec_t;

  rec_t       q[$];
  rec_t       last_e;
  int         bias;
  bit         prev_busy;
  logic [7:0] last_wra, last_nra;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic rec_t mk(logic [5:0] f, logic [7:0] w, logic [7:0] n,
                              logic [7:0] o, bit rc, bit wc);
    rec_t r;
    r.flags = f; r.wra = w; r.nra = n; r.nwa = o; r.rd_chk = rc; r.wr_chk = wc;
    return r;
  endfunction

  // Expected operation list for one layer, straight from the layer rules.
  task automatic build(input int ni, input int no, input int wb, input int ib, input int ob);
    q.delete();
    if (ni != 0 && no != 0) begin
      for (int j = 0; j < no; j++) begin
        for (int k = 0; k < ni + bias; k++)
          q.push_back(mk({1'b1, 1'b0, 1'b1, (k == 0), (bias == 1 && k == ni), 1'b0},
                         8'(wb + j * (ni + bias) + k), 8'(ib + k), 8'h00, 1'b1, 1'b0));
        q.push_back(mk(6'b100001, 8'h00, 8'h00, 8'(ob + j), 1'b0, 1'b1));
      end
    end
    q.push_back(mk(6'b110000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
  endtask

  task automatic check(input string tag, input rec_t e);
    logic [5:0] of;
    logic [7:0] ow, onr, onw;
    if (bias == 1) begin
      of  = {bus1.busy, bus1.finished, bus1.mac_valid, bus1.acc_clear, bus1.bias_sel, bus1.write_en};
      ow  = bus1.weight_read_addr; onr = bus1.neuro_read_addr; onw = bus1.neuro_write_addr;
    end else begin
      of  = {bus0.busy, bus0.finished, bus0.mac_valid, bus0.acc_clear, bus0.bias_sel, bus0.write_en};
      ow  = bus0.weight_read_addr; onr = bus0.neuro_read_addr; onw = bus0.neuro_write_addr;
    end
    vectors++;
    assert (of === e.flags) else begin
      miscompares++;
      $error("FAIL %s flags(busy,fin,mv,ac,bs,we) observed %b expected %b", tag, of, e.flags);
    end
    if (e.rd_chk) begin
      vectors++;
      assert ({ow, onr} === {e.wra, e.nra}) else begin
        miscompares++;
        $error("FAIL %s read addrs observed w=%h n=%h expected w=%h n=%h", tag, ow, onr, e.wra, e.nra);
      end
    end
    if (e.wr_chk) begin
      vectors++;
      assert (onw === e.nwa) else begin
        miscompares++;
        $error("FAIL %s write addr observed %h expected %h", tag, onw, e.nwa);
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    prev_busy = 1'b0;
    last_wra  = 8'h00;
    last_nra  = 8'h00;
    last_e    = mk(6'b000000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  // One clock: drive inputs at negedge, predict and compare after posedge.
  task automatic cycle(input string tag, input bit st, input bit sl,
                       input logic [7:0] ni, input logic [7:0] no,
                       input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob);
    rec_t e;
    bit   launched;
    @(negedge clk);
    start = st; stall = sl; n_in = ni; n_out = no; w_base = wb; in_base = ib; out_base = ob;
    @(posedge clk);
    #1;
    launched = 1'b0;
    if (q.size() == 0 && st && !prev_busy) begin
      build(int'(ni), int'(no), int'(wb), int'(ib), int'(ob));
      launched = 1'b1;
    end
    if (q.size() == 0) begin
      e = mk(6'b000000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    end else if (sl && !launched && (q[0].flags[3] || q[0].flags[0])) begin
      e = mk(6'b100000, last_wra, last_nra, 8'h00, 1'b1, 1'b0);
    end else begin
      e = q.pop_front();
      if (e.flags[3]) begin
        last_wra = e.wra;
        last_nra = e.nra;
      end
    end
    prev_busy = e.flags[5];
    last_e = e;
    check(tag, e);
  endtask

  // mode: 0 no stall, 1 random stall, 2 three-cycle stall over the 2nd MAC
  task automatic run_layer(input string tag, input logic [7:0] ni, input logic [7:0] no,
                           input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob,
                           input int mode, input bit spam);
    int idx;
    cycle(tag, 1'b1, (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0, ni, no, wb, ib, ob);
    idx = 0;
    while (q.size() != 0 && idx < 2000) begin
      bit sl;
      bit st;
      sl = (mode == 1) ? ($urandom_range(0, 99) < 30) : (mode == 2) ? (idx >= 1 && idx <= 3) : 1'b0;
      st = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle(tag, st, sl, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      idx++;
    end
    cycle({tag, "_idle"}, 1'b0, 1'($urandom_range(0, 1)), ni, no, wb, ib, ob);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("reset", mk(6'b000000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1));
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    start = 0; stall = 0; n_in = 0; n_out = 0; w_base = 0; in_base = 0; out_base = 0;
    bias = 1;
    model_reset();
    apply_reset();

    // ---- bias term enabled ----
    run_layer("basic", 8'd3, 8'd2, 8'h10, 8'h40, 8'h80, 0, 1'b0);
    run_layer("stall3", 8'd3, 8'd2, 8'h10, 8'h40, 8'h80, 2, 1'b0);
    run_layer("nout0", 8'd3, 8'd0, 8'h10, 8'h40, 8'h80, 1, 1'b0);
    run_layer("nin0", 8'd0, 8'd2, 8'h10, 8'h40, 8'h80, 0, 1'b0);
    run_layer("spam", 8'd3, 8'd2, 8'h10, 8'h40, 8'h80, 0, 1'b1);
    run_layer("wrap1", 8'd2, 8'd3, 8'hFB, 8'hFF, 8'hFE, 1, 1'b0);
    for (int n = 0; n < 6; n++)
      run_layer("rand1", 8'($urandom_range(1, 5)), 8'($urandom_range(1, 4)),
                8'($urandom), 8'($urandom), 8'($urandom), 1, 1'($urandom_range(0, 1)));

    // Reset while a write is being presented: everything clears at once.
    cycle("rst_mid", 1'b1, 1'b0, 8'd2, 8'd3, 8'h20, 8'h50, 8'h90);
    for (int n = 0; n < 100 && !last_e.flags[0]; n++)
      cycle("rst_mid", 1'b0, 1'b0, 8'd2, 8'd3, 8'h20, 8'h50, 8'h90);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_reset", mk(6'b000000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    check("reset_hold", mk(6'b000000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1));
    @(negedge clk);
    reset = 1'b1;
    run_layer("post_rst", 8'd2, 8'd3, 8'h20, 8'h50, 8'h90, 0, 1'b0);

    // ---- bias term disabled ----
    bias = 0;
    apply_reset();
    run_layer("wrap0", 8'd4, 8'd1, 8'hFE, 8'h40, 8'h80, 0, 1'b0);
    run_layer("nin1", 8'd1, 8'd3, 8'h30, 8'h60, 8'hA0, 1, 1'b0);
    run_layer("nout0_b0", 8'd2, 8'd0, 8'h30, 8'h60, 8'hA0, 0, 1'b0);
    for (int n = 0; n < 6; n++)
      run_layer("rand0", 8'($urandom_range(1, 5)), 8'($urandom_range(1, 4)),
                8'($urandom), 8'($urandom), 8'($urandom), 1, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
